// File: rtl/uart_pkg.sv
// Shared UART definitions: frame length, bit-counter width, FSM states and
// the parity helper used by both the transmit and receive engines.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int BITCNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    SENDING = 2'd2
  } uart_state_e;

  // XOR of the data bits actually on the line (bit 7 only in 8-bit mode),
  // inverted for odd parity.
  function automatic logic uart_parity(input logic [7:0] data,
                                       input logic       eight,
                                       input logic       ohel);
    uart_parity = (^data[6:0]) ^ (eight & data[7]) ^ ohel;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time and bit counters for the UART engines. BTU pulses at the end of
// every bit time while DOIT is high; DONE marks the BTU that ends the last
// bit. HALF_START shortens the first bit time to K/2 so a receiver can
// sample mid-bit; the transmitter uses the full-K variant.
module uart_bit_timer #(
  parameter int BAUD_W     = 19,
  parameter int NBITS      = 11,
  parameter bit HALF_START = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DOIT,
  input  logic [BAUD_W-1:0] K,
  output logic              BTU,
  output logic              DONE
);
  import uart_pkg::*;

  localparam logic [BAUD_W-1:0]   ONE_K   = BAUD_W'(1);
  localparam logic [BITCNT_W-1:0] ONE_B   = BITCNT_W'(1);
  localparam logic [BITCNT_W-1:0] LAST_B  = BITCNT_W'(NBITS - 1);

  logic [BAUD_W-1:0]   r_cnt;
  logic [BITCNT_W-1:0] r_bit;
  logic [BAUD_W-1:0]   w_term;

  // Terminal count of the current bit time.
  always_comb begin
    w_term = K - ONE_K;
    if (HALF_START && (r_bit == '0)) w_term = (K >> 1) - ONE_K;
  end

  assign BTU  = DOIT && (r_cnt == w_term);
  assign DONE = BTU && (r_bit == LAST_B);

  // Counters idle at zero whenever no frame is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else if (!DOIT || DONE) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else if (BTU) begin
      r_cnt <= '0;
      r_bit <= r_bit + ONE_B;
    end else begin
      r_cnt <= r_cnt + ONE_K;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: one byte per accepted LOAD becomes an 11-bit-time
// frame (start, 7/8 data LSB-first, optional parity, stop/idle fill).
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_engine #(
  parameter int BAUD_W     = 19,
  parameter int FRAME_BITS = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              LOAD,
  input  logic [7:0]        OUT_PORT,
  input  logic              EIGHT,
  input  logic              PEN,
  input  logic              OHEL,
  input  logic [BAUD_W-1:0] BAUD_K,
`ifdef UART_TX_BREAK_EN
  input  logic              BREAK,
`endif
  output logic              TX,
  output logic              TXRDY
);
  import uart_pkg::*;

  localparam logic [BAUD_W-1:0] ONE_K = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] MIN_K = BAUD_W'(2);

  uart_state_e       r_state, w_next;
  logic [10:0]       r_sr;
  logic [7:0]        r_data;
  logic              r_eight, r_pen, r_ohel;
  logic [BAUD_W-1:0] r_k;

  logic              w_doit, w_btu, w_done, w_accept, w_par, w_bit8, w_bit9;
  logic [10:0]       w_frame;
  logic [BAUD_W-1:0] w_k_norm;
  logic              w_brk, w_brk_rec;

  // Bit times shorter than two clocks are not representable.
  assign w_k_norm = (BAUD_K < MIN_K) ? MIN_K : BAUD_K;
  assign w_accept = LOAD && TXRDY;

`ifdef UART_TX_BREAK_EN
  logic              r_brk_rec;
  logic [BAUD_W-1:0] r_brk_cnt;

  assign w_brk     = BREAK;
  assign w_brk_rec = r_brk_rec;

  // After BREAK drops, keep the line idle-high but not ready for one bit time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_brk_rec <= 1'b0;
      r_brk_cnt <= '0;
    end else if (BREAK) begin
      r_brk_rec <= 1'b1;
      r_brk_cnt <= '0;
    end else if (r_brk_rec) begin
      if (r_brk_cnt == r_k - ONE_K) begin
        r_brk_rec <= 1'b0;
        r_brk_cnt <= '0;
      end else begin
        r_brk_cnt <= r_brk_cnt + ONE_K;
      end
    end
  end
`else
  assign w_brk     = 1'b0;
  assign w_brk_rec = 1'b0;
`endif

  // Frame image b10..b0, b0 being the start bit.
  assign w_par   = uart_parity(r_data, r_eight, r_ohel);
  assign w_bit8  = r_eight ? r_data[7] : (r_pen ? w_par : 1'b1);
  assign w_bit9  = r_eight ? (r_pen ? w_par : 1'b1) : 1'b1;
  assign w_frame = {1'b1, w_bit9, w_bit8, r_data[6:0], 1'b0};

  uart_bit_timer #(
    .BAUD_W     (BAUD_W),
    .NBITS      (FRAME_BITS),
    .HALF_START (1'b0)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .DOIT (w_doit),
    .K    (r_k),
    .BTU  (w_btu),
    .DONE (w_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a break always drops the engine back to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = LOADING;
      LOADING: w_next = SENDING;
      SENDING: if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_brk) w_next = IDLE;
  end

  // Outputs decoded from state.
  always_comb begin
    w_doit = (r_state == SENDING);
    TXRDY  = (r_state == IDLE) && !w_brk && !w_brk_rec;
    TX     = (r_state == SENDING) ? r_sr[0] : 1'b1;
    if (w_brk) TX = 1'b0;
  end

  // Format/data latch on accept, frame load, and shift on each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr    <= '1;
      r_data  <= '0;
      r_eight <= 1'b0;
      r_pen   <= 1'b0;
      r_ohel  <= 1'b0;
      r_k     <= MIN_K;
    end else if (w_brk) begin
      r_sr <= '1;
      r_k  <= w_k_norm;
    end else if (w_accept) begin
      r_data  <= OUT_PORT;
      r_eight <= EIGHT;
      r_pen   <= PEN;
      r_ohel  <= OHEL;
      r_k     <= w_k_norm;
    end else if (r_state == LOADING) begin
      r_sr <= w_frame;
    end else if (w_btu) begin
      r_sr <= {1'b1, r_sr[10:1]};
    end
  end

endmodule
